// File: rtl/led_pattern_pkg.sv
// Shared constants for the led_pattern LED driver.
//   MODE_*     : per-channel mode encodings carried on mode_i
//   HEART_MASK : heartbeat pattern, bit n is the LED level at phase n
package led_pattern_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_HEART = 2'd3;

  // Lit at phases 0 and 2 only: 10100000 over eight ticks.
  localparam logic [7:0] HEART_MASK = 8'b00000101;

  typedef logic [2:0] phase_t;

endpackage

// File: rtl/led_pattern_if.sv
// Control/status bundle of the led_pattern driver.
//   mode_i : 2 bits per channel, channel k at [2k+1:2k]
//   duty_i : PWM_BITS per channel brightness (only used with LED_PATTERN_PWM_EN)
//   tick_o : one-cycle pulse per base tick
//   led_o  : registered active-high LED drive
// master drives modes/duties, slave (the driver) returns tick and LEDs.
interface led_pattern_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PWM_BITS = 4
);

  logic [2*CHANNELS-1:0]        mode_i;
  logic [PWM_BITS*CHANNELS-1:0] duty_i;
  logic                         tick_o;
  logic [CHANNELS-1:0]          led_o;

  modport master (
    output mode_i,
    output duty_i,
    input  tick_o,
    input  led_o
  );

  modport slave (
    input  mode_i,
    input  duty_i,
    output tick_o,
    output led_o
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: mode shadow, 3-bit phase counter, pattern decode and
// (with LED_PATTERN_PWM_EN defined) the duty compare against the shared PWM count.
//   clock, reset_n : clock, async active-low reset
//   tick_i         : shared base tick
//   mode_i         : this channel's requested mode
//   duty_i         : brightness (PWM build only)
//   pwm_cnt_i      : shared free-running PWM count (PWM build only)
//   led_o          : registered LED drive
module led_channel
  import led_pattern_pkg::*;
`ifdef LED_PATTERN_PWM_EN
#(
  parameter int unsigned PWM_BITS = 4
)
`endif
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick_i,
  input  logic [1:0]          mode_i,
`ifdef LED_PATTERN_PWM_EN
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
`endif
  output logic                led_o
);

  logic [1:0] mode_q;
  phase_t     phase_q, phase_d;
  logic       pattern;
  logic       led_q, led_d;

  // A mode change restarts the pattern and wins over a coincident tick.
  always_comb begin
    phase_d = phase_q;
    if (mode_i != mode_q) begin
      phase_d = '0;
    end else if (tick_i) begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_comb begin
    pattern = 1'b0;
    unique case (mode_q)
      MODE_OFF:   pattern = 1'b0;
      MODE_ON:    pattern = 1'b1;
      MODE_BLINK: pattern = ~phase_q[0];
      MODE_HEART: pattern = HEART_MASK[phase_q];
    endcase
  end

`ifdef LED_PATTERN_PWM_EN
  assign led_d = pattern & (pwm_cnt_i < duty_i);
`else
  assign led_d = pattern;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_OFF;
      phase_q <= '0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_i;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern.sv
// Multi-channel LED indicator driver. A shared prescaler divides the clock by
// CYCLES to form the base tick; each channel runs off/on/blink/heartbeat.
// Optional feature macro: LED_PATTERN_PWM_EN adds a free-running PWM_BITS counter
// that dims lit channels by their duty value.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus_io  : led_pattern_if slave (mode_i, duty_i in; tick_o, led_o out)
module led_pattern
  import led_pattern_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CYCLES   = 6000000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  led_pattern_if.slave  bus_io
);

  localparam int unsigned    CntW   = $clog2(CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(CYCLES - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tick;
  logic [CHANNELS-1:0] led;

  // tick is decoded from the registered count, so async reset clears it at once.
  assign tick  = (cnt_q == CntMax);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end
`else
  localparam int unsigned DutyW = PWM_BITS * CHANNELS;
  logic [DutyW-1:0] unused_duty;
  assign unused_duty = bus_io.duty_i;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
`ifdef LED_PATTERN_PWM_EN
    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick_i    (tick),
      .mode_i    (bus_io.mode_i[2*k +: 2]),
      .duty_i    (bus_io.duty_i[PWM_BITS*k +: PWM_BITS]),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led[k])
    );
`else
    led_channel u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .tick_i  (tick),
      .mode_i  (bus_io.mode_i[2*k +: 2]),
      .led_o   (led[k])
    );
`endif
  end

  assign bus_io.tick_o = tick;
  assign bus_io.led_o  = led;

endmodule
